rd_data_master_arb: RTL and testbench
=====================================

# rd_data_master_arb

Read-data response arbiter between the M read-data sources and the N upstream masters. It routes each beat to the master named by `in_pld[i].txnid.master_id`. When several sources target the same master in one cycle, a per-master round-robin arbiter picks one winner and the losers are back-pressured. Each master has a one-entry output register with valid/ready, so crossbar conflicts are resolved in hardware.

## Interface
- `M`, default 8: number of read-data sources.
- `N`, default 16: number of masters. `master_id` is `$clog2(N)` bits wide.
- `clk`  in  1: clock; all state is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_vld`  in  [M-1:0]: source beat valid.
- `in_rdy`  out  [M-1:0]: source beat accepted this cycle.
- `in_pld`  in  `us_data_pld_t [M-1:0]`: source payload. The destination is `txnid.master_id`.
- `out_vld`  out  [N-1:0]: per-master beat valid, driven from a register.
- `out_rdy`  in  [N-1:0]: per-master accept.
- `out_pld`  out  `us_data_pld_t [N-1:0]`: per-master payload, driven from a register.
- `id_err`  out  1: sticky flag, set when a beat carries `master_id >= N`.

## Operation
- Destination of source i: `sel[i] = in_pld[i].txnid.master_id`.
- Request matrix: `req[j][i] = in_vld[i] & (sel[i]==j)`.
- Per master j, register `rr_ptr[j]` (0..M-1) marks the highest-priority source. Priority runs from `rr_ptr[j]` upward, wrapping from M-1 to 0.
- `can_load[j] = !out_vld[j] | out_rdy[j]`.
- `gnt[j][i]` is one-hot in i. It is asserted only if `can_load[j]` and `req[j][i]` is set, and i is the first requester in priority order.
- `in_rdy[i]` is the OR over j of `gnt[j][i]`. If `sel[i] >= N`, `in_rdy[i] = in_vld[i]`, the beat is dropped and `id_err` is set.
- On a grant to k for master j:
  - `out_pld[j] <= in_pld[k]`.
  - `out_vld[j] <= 1`.
  - `rr_ptr[j] <= (k+1) mod M`.
- Without a grant:
  - If `out_vld[j] & out_rdy[j]`, then `out_vld[j] <= 0`.
  - Otherwise `out_vld[j]` and `out_pld[j]` hold.
- `rr_ptr[j]` changes only on a grant to master j.
- A source that loses arbitration sees `in_rdy=0`. It must hold `in_vld` and `in_pld` stable until accepted.
- Each master is independent. Up to min(M,N) beats can move per cycle when all destinations differ.
- `id_err` clears only on reset.

## Timing
- Reset values:
  - `out_vld` = 0.
  - `out_pld` = 0.
  - `rr_ptr` = 0 for all masters.
  - `id_err` = 0.
  - `in_rdy` = 0, because it is combinational and `in_vld` is 0 or nothing is granted.
- Latency: a beat accepted in cycle t has `out_vld` high in cycle t+1.
- Throughput: one beat per master per cycle. With `out_rdy` tied high, back-to-back beats flow with no bubble.
- Backpressure: while `out_vld[j]=1` and `out_rdy[j]=0`, `out_pld[j]` is stable, no grant is made for j, and every requester of j sees `in_rdy=0`.
- Combinational paths: `in_rdy` depends on `in_vld`, `in_pld` and `out_rdy`. Sources must not derive `in_vld` from `in_rdy`.
- Simultaneous drain and load: if `out_rdy[j]=1` and a grant happens in the same cycle, the new beat replaces the old one. `out_vld` stays 1 and there is no bubble.
- Reset asserted mid-transfer: all output beats are discarded immediately and asynchronously. Sources must re-present their beats after reset.
- Fairness: with k persistent requesters on one master, each is granted once every k grants.

## Test plan
- Single beat:
  - Stimulus: source 3 sends a beat with `master_id=5`, all `out_rdy=1`.
  - Response: `in_rdy[3]=1` in cycle t, then `out_vld[5]=1` with the matching payload in cycle t+1, then `out_vld[5]=0` in cycle t+2. `rr_ptr[5]=4`.
- Conflict:
  - Stimulus: sources 0, 2 and 7 all hold beats for master 1, `out_rdy[1]=1`, starting from reset.
  - Response: grants occur in order 0, 2, 7 on consecutive cycles, and losers see `in_rdy=0`. A second round with the same requesters is again granted 0, 2, 7.
- Backpressure:
  - Stimulus: master 4 has `out_rdy=0` for 5 cycles while sources 1 and 6 target it.
  - Response: `out_pld[4]` holds the first beat, `in_rdy[1]` and `in_rdy[6]` stay 0. On release, `out_vld` stays high and the next winner loads with no bubble.
- Parallel routing:
  - Stimulus: all 8 sources target distinct masters 0..7 in one cycle.
  - Response: all `in_rdy=1` and all 8 `out_vld` are high the next cycle, each with its correct payload.
- Invalid ID:
  - Stimulus: N=12, source 0 sends `master_id=13`.
  - Response: `in_rdy[0]=1`, no `out_vld` rises, and `id_err` goes to 1 and stays set.
- Reset mid-operation:
  - Stimulus: `rst_n` is driven low while `out_vld[2]=1` is stalled.
  - Response: `out_vld` is 0 immediately, and after release the pointers are at 0 and the first grant goes to the lowest-index requester.

Source files
------------

// File: rtl/rd_data_master_arb.sv
// Read-data response crossbar: routes source beats to per-master output registers,
// resolving per-master conflicts with independent round-robin arbiters.
package rd_data_master_arb_pkg;
    localparam int MASTER_ID_W = 4;

    typedef struct packed {
        logic [MASTER_ID_W-1:0] master_id;
        logic [3:0]             tag;
    } txnid_t;

    typedef struct packed {
        txnid_t      txnid;
        logic [31:0] data;
        logic        last;
    } us_data_pld_t;
endpackage

module rd_data_master_arb
    import rd_data_master_arb_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 16,
    localparam int PTR_W = (M > 1) ? $clog2(M) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [M-1:0]            in_vld,
    output logic [M-1:0]            in_rdy,
    input  us_data_pld_t [M-1:0]    in_pld,
    output logic [N-1:0]            out_vld,
    input  logic [N-1:0]            out_rdy,
    output us_data_pld_t [N-1:0]    out_pld,
    output logic                    id_err,
    output logic [N*PTR_W-1:0]      dbg_rr_ptr
);
    // Handshake: a beat moves on a side when vld & rdy are both high at the rising edge.
    // in_rdy is combinational from in_vld/in_pld/out_rdy; out_vld/out_pld are registered.

    logic [N-1:0]          out_vld_q, out_vld_d;
    us_data_pld_t [N-1:0]  out_pld_q, out_pld_d;
    logic [PTR_W-1:0]      rr_ptr_q [N];
    logic [PTR_W-1:0]      rr_ptr_d [N];
    logic                  id_err_q, id_err_d;

    logic [N-1:0]          can_load;
    logic [N-1:0]          gnt_any;
    logic [M-1:0]          gnt [N];
    logic [PTR_W-1:0]      win [N];
    logic [M-1:0]          bad_id;
    int                    idx;

    always_comb begin
        idx      = 0;
        can_load = '0;
        gnt_any  = '0;
        bad_id   = '0;
        for (int i = 0; i < M; i++) begin
            bad_id[i] = int'(in_pld[i].txnid.master_id) >= N;
        end
        for (int j = 0; j < N; j++) begin
            gnt[j]      = '0;
            win[j]      = '0;
            can_load[j] = !out_vld_q[j] | out_rdy[j];
            // Scan sources starting at the pointer, wrapping; first requester wins.
            for (int o = 0; o < M; o++) begin
                idx = int'(rr_ptr_q[j]) + o;
                if (idx >= M) idx = idx - M;
                if (!gnt_any[j] && can_load[j] && in_vld[idx] &&
                    int'(in_pld[idx].txnid.master_id) == j) begin
                    gnt[j][idx] = 1'b1;
                    gnt_any[j]  = 1'b1;
                    win[j]      = PTR_W'(idx);
                end
            end
        end
    end

    always_comb begin
        in_rdy   = in_vld & bad_id;
        id_err_d = id_err_q | (|(in_vld & bad_id));
        for (int j = 0; j < N; j++) begin
            in_rdy = in_rdy | gnt[j];
            if (gnt_any[j]) begin
                out_vld_d[j] = 1'b1;
                out_pld_d[j] = in_pld[win[j]];
                rr_ptr_d[j]  = (win[j] == PTR_W'(M - 1)) ? '0 : win[j] + 1'b1;
            end else begin
                out_vld_d[j] = out_vld_q[j] & !out_rdy[j];
                out_pld_d[j] = out_pld_q[j];
                rr_ptr_d[j]  = rr_ptr_q[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= '0;
            out_pld_q <= '0;
            id_err_q  <= 1'b0;
            for (int j = 0; j < N; j++) rr_ptr_q[j] <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_pld_q <= out_pld_d;
            id_err_q  <= id_err_d;
            for (int j = 0; j < N; j++) rr_ptr_q[j] <= rr_ptr_d[j];
        end
    end

    always_comb begin
        dbg_rr_ptr = '0;
        for (int j = 0; j < N; j++) dbg_rr_ptr[j*PTR_W +: PTR_W] = rr_ptr_q[j];
    end

    assign out_vld = out_vld_q;
    assign out_pld = out_pld_q;
    assign id_err  = id_err_q;
endmodule

// File: tb/tb_rd_data_master_arb.sv
// Directed bench for rd_data_master_arb (M=8, N=12 so out-of-range ids are reachable).
module tb_rd_data_master_arb;
    import rd_data_master_arb_pkg::*;

    localparam int M = 8;
    localparam int N = 12;
    localparam int PW = 3;

    logic                 clk;
    logic                 rst_n;
    logic [M-1:0]         in_vld;
    logic [M-1:0]         in_rdy;
    us_data_pld_t [M-1:0] in_pld;
    logic [N-1:0]         out_vld;
    logic [N-1:0]         out_rdy;
    us_data_pld_t [N-1:0] out_pld;
    logic                 id_err;
    logic [N*PW-1:0]      dbg_rr_ptr;

    int checks = 0;
    int errors = 0;

    rd_data_master_arb #(.M(M), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_pld(in_pld),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_pld(out_pld),
        .id_err(id_err), .dbg_rr_ptr(dbg_rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic us_data_pld_t mk(input int mid, input logic [31:0] data);
        us_data_pld_t p;
        p = '0;
        p.txnid.master_id = 4'(mid);
        p.txnid.tag       = 4'(data[3:0]);
        p.data            = data;
        p.last            = 1'b1;
        return p;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = '0;
        in_pld  = '0;
        out_rdy = '1;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        in_vld  = '0;
        in_pld  = '0;
        out_rdy = '1;
        rst_n   = 1'b0;
        #3;
        checks++;
        if (out_vld !== '0) begin errors++; $display("FAIL reset_out_vld got=%h exp=0", out_vld); end
        checks++;
        if (out_pld !== '0) begin errors++; $display("FAIL reset_out_pld got=%h exp=0", out_pld); end
        checks++;
        if (in_rdy !== '0) begin errors++; $display("FAIL reset_in_rdy got=%h exp=0", in_rdy); end
        checks++;
        if (id_err !== 1'b0) begin errors++; $display("FAIL reset_id_err got=%b exp=0", id_err); end
        checks++;
        if (dbg_rr_ptr !== '0) begin errors++; $display("FAIL reset_rr_ptr got=%h exp=0", dbg_rr_ptr); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        us_data_pld_t b;
        do_reset();
        b = mk(5, 32'hA5A5_0003);
        in_pld[3] = b;
        in_vld    = 8'b0000_1000;
        #1;
        checks++;
        if (in_rdy !== 8'b0000_1000) begin errors++; $display("FAIL single_in_rdy got=%b exp=00001000", in_rdy); end
        step();
        in_vld = '0;
        checks++;
        if (out_vld !== 12'h020) begin errors++; $display("FAIL single_out_vld got=%h exp=020", out_vld); end
        checks++;
        if (out_pld[5] !== b) begin errors++; $display("FAIL single_out_pld got=%h exp=%h", out_pld[5], b); end
        checks++;
        if (dbg_rr_ptr[5*PW +: PW] !== 3'd4) begin errors++; $display("FAIL single_rr_ptr got=%0d exp=4", dbg_rr_ptr[5*PW +: PW]); end
        step();
        checks++;
        if (out_vld !== '0) begin errors++; $display("FAIL single_drain got=%h exp=0", out_vld); end
    endtask

    task automatic test_conflict();
        int order [6] = '{0, 2, 7, 0, 2, 7};
        do_reset();
        in_pld[0] = mk(1, 32'h1000_0000);
        in_pld[2] = mk(1, 32'h1000_0002);
        in_pld[7] = mk(1, 32'h1000_0007);
        in_vld    = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (in_rdy !== 8'(1 << order[k])) begin
                errors++; $display("FAIL conflict_gnt[%0d] got=%b exp_src=%0d", k, in_rdy, order[k]);
            end
            step();
            checks++;
            if (out_vld[1] !== 1'b1 || out_pld[1].data !== 32'h1000_0000 + 32'(order[k])) begin
                errors++; $display("FAIL conflict_out[%0d] got_vld=%b got_data=%h exp_src=%0d", k, out_vld[1], out_pld[1].data, order[k]);
            end
        end
        in_vld = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_rdy[4] = 1'b0;
        in_pld[1]  = mk(4, 32'h4000_0001);
        in_pld[6]  = mk(4, 32'h4000_0006);
        in_vld     = 8'b0100_0010;
        #1;
        checks++;
        if (in_rdy !== 8'b0000_0010) begin errors++; $display("FAIL bp_first_gnt got=%b exp=00000010", in_rdy); end
        step();
        in_vld = 8'b0100_0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (in_rdy !== '0 || out_vld[4] !== 1'b1 || out_pld[4].data !== 32'h4000_0001) begin
                errors++; $display("FAIL bp_hold[%0d] got_rdy=%b got_vld=%b got_data=%h exp_data=40000001", c, in_rdy, out_vld[4], out_pld[4].data);
            end
            step();
        end
        out_rdy[4] = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 8'b0100_0000) begin errors++; $display("FAIL bp_release_gnt got=%b exp=01000000", in_rdy); end
        step();
        in_vld = '0;
        checks++;
        if (out_vld[4] !== 1'b1 || out_pld[4].data !== 32'h4000_0006) begin
            errors++; $display("FAIL bp_no_bubble got_vld=%b got_data=%h exp_data=40000006", out_vld[4], out_pld[4].data);
        end
        step();
        checks++;
        if (out_vld[4] !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_vld[4]); end
    endtask

    task automatic test_parallel();
        do_reset();
        for (int i = 0; i < M; i++) in_pld[i] = mk(7 - i, 32'hC000_0000 + 32'(i));
        in_vld = '1;
        #1;
        checks++;
        if (in_rdy !== 8'hFF) begin errors++; $display("FAIL par_in_rdy got=%b exp=11111111", in_rdy); end
        step();
        in_vld = '0;
        checks++;
        if (out_vld !== 12'h0FF) begin errors++; $display("FAIL par_out_vld got=%h exp=0ff", out_vld); end
        for (int i = 0; i < M; i++) begin
            checks++;
            if (out_pld[7 - i].data !== 32'hC000_0000 + 32'(i)) begin
                errors++; $display("FAIL par_pld[%0d] got=%h exp=%h", 7 - i, out_pld[7 - i].data, 32'hC000_0000 + 32'(i));
            end
        end
        step();
    endtask

    task automatic test_invalid_id();
        do_reset();
        in_pld[0] = mk(13, 32'hDEAD_0000);
        in_pld[1] = mk(12, 32'hDEAD_0001);
        in_vld    = 8'b0000_0011;
        #1;
        checks++;
        if (in_rdy !== 8'b0000_0011) begin errors++; $display("FAIL badid_in_rdy got=%b exp=00000011", in_rdy); end
        checks++;
        if (id_err !== 1'b0) begin errors++; $display("FAIL badid_err_early got=%b exp=0", id_err); end
        step();
        in_vld = '0;
        checks++;
        if (out_vld !== '0) begin errors++; $display("FAIL badid_out_vld got=%h exp=0", out_vld); end
        checks++;
        if (id_err !== 1'b1) begin errors++; $display("FAIL badid_err_set got=%b exp=1", id_err); end
        step();
        step();
        checks++;
        if (id_err !== 1'b1) begin errors++; $display("FAIL badid_err_sticky got=%b exp=1", id_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy[2] = 1'b0;
        in_pld[5]  = mk(2, 32'h2000_0005);
        in_vld     = 8'b0010_0000;
        step();
        in_vld = '0;
        checks++;
        if (out_vld[2] !== 1'b1) begin errors++; $display("FAIL rmid_stall_vld got=%b exp=1", out_vld[2]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_vld !== '0) begin errors++; $display("FAIL rmid_async_clear got=%h exp=0", out_vld); end
        checks++;
        if (dbg_rr_ptr !== '0) begin errors++; $display("FAIL rmid_rr_ptr got=%h exp=0", dbg_rr_ptr); end
        step();
        rst_n      = 1'b1;
        out_rdy[2] = 1'b1;
        step();
        in_pld[3] = mk(2, 32'h2000_0003);
        in_pld[6] = mk(2, 32'h2000_0006);
        in_vld    = 8'b0100_1000;
        #1;
        checks++;
        if (in_rdy !== 8'b0000_1000) begin errors++; $display("FAIL rmid_first_gnt got=%b exp=00001000", in_rdy); end
        step();
        in_vld = '0;
        checks++;
        if (out_pld[2].data !== 32'h2000_0003) begin errors++; $display("FAIL rmid_first_pld got=%h exp=20000003", out_pld[2].data); end
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = '0;
        in_pld  = '0;
        out_rdy = '1;
        test_reset();
        test_single();
        test_conflict();
        test_backpressure();
        test_parallel();
        test_invalid_id();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
